alu_regfile_pipe: RTL
=====================

Name: alu_regfile_pipe

Overview:
- Parametrised, two-stage pipelined successor to the team's 4x8-bit ALU/register-file block.
- Holds NREGS x DATA_W registers. Executes the same eight-op ALU set (ADD, INV, AND, OR, SHR, SHL, BEQ, BNE) with zero/immediate operand muxing.
- Adds valid/ready flow control, automatic writeback with forwarding, and a host load port.
- Sits between instruction decode and branch/PC logic of the en/de-cryption datapath.

Parameters:
DATA_W, 8, datapath and register width (>=4)
NREGS, 4, number of registers (power of two, >=2)
ADDR_W, $clog2(NREGS), register address width (derived, not overridden)
SH_W, $clog2(DATA_W), shift-amount width (derived)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  instruction offered
in_ready  out  1  instruction accepted when in_valid&&in_ready
op  in  3  0 ADD, 1 INV, 2 AND, 3 OR, 4 SHR, 5 SHL, 6 BEQ, 7 BNE
rs0, rs1, rd  in  ADDR_W each  source/destination addresses
wb_en  in  1  write result to rd
src0_sel, src1_sel  in  2 each  0 register, 1 zero, 2 imm, 3 zero
imm  in  DATA_W  immediate operand
ext_wr_en  in  1  host register load
ext_wr_addr  in  ADDR_W  host load address
ext_wr_data  in  DATA_W  host load data
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid&&out_ready
result  out  DATA_W  ALU result
ovf  out  1  signed overflow (ADD only)
take_branch  out  1  branch decision (BEQ/BNE only)
out_rd  out  ADDR_W  destination of result
out_wb  out  1  result will be written back

Behaviour:
- Reset: all registers, S1/S2 valids, result, ovf, take_branch, out_rd, out_wb = 0; in_ready = 1 after reset. Reset mid-operation discards in-flight instructions with no writeback.
- Pipeline:
  - S1 captures op/addresses/operands on accept.
  - S2 holds the computed result and drives the outputs.
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_adv.
  - in_ready = !s1_valid || s2_adv (combinational from out_ready, no input-to-output path).
- Latency: accepted at edge N gives out_valid after edge N+1 under no backpressure. Throughput is 1/cycle. Outputs hold stable while out_valid && !out_ready.
- Register read at accept is write-through: a same-cycle writeback or ext write to rs is visible.
- Writeback: on the output handshake with out_wb=1, result is written to out_rd. BEQ/BNE force out_wb=0 regardless of wb_en.
- Forwarding: on s1_adv, if S2 valid && out_wb && out_rd==rs (for src_sel=0), use S2 result instead of the captured value, per operand independently.
- Ext write vs writeback, same address, same cycle: writeback wins and the ext write is dropped. Different addresses: both are written.
- An ext write after capture is not seen by instructions already in S1.
- Arithmetic, a = operand0, b = operand1:
  - ADD: result = (a+b) mod 2^DATA_W; ovf = sign(a)==sign(b) && sign(result)!=sign(a).
  - INV: ~b.
  - AND: a&b.
  - OR: a|b.
  - SHR: a >> b[SH_W-1:0], logical.
  - SHL: a << b[SH_W-1:0].
  - BEQ: result = 0, take_branch = (a==b).
  - BNE: result = 0, take_branch = (a!=b).
  - ovf = 0 and take_branch = 0 for non-applicable ops.

Test Plan:
- Load r1=92, r2=65; ADD rd=r3, rs0=r1, rs1=r2, wb_en=1 -> result=157, ovf=1, out_valid 2 edges after accept; r3 reads 157 afterwards.
- Load r0=99; ADD src1_sel=2, imm=130 -> result=229, ovf=0. Load r0=r1=127; ADD -> 254, ovf=1.
- Back-to-back r1=r1+r2 three times (r1=1, r2=1, out_ready=1) -> results 2, 3, 4 via forwarding, no bubbles.
- Hold out_ready=0 for 5 cycles with 3 instructions offered -> in_ready falls after 2 accepts, result held; release -> results in order, none lost or duplicated.
- r2=129: SHR b=1 -> 64; SHL b=1 -> 2; r0=r1=24: BEQ -> take_branch=1, BNE -> 0, no register changes; OR 241|15 -> 255; AND 55&100 -> 36; INV 240 -> 15.
- Assert rst while 2 instructions are in flight -> all outputs 0 next edge, registers 0, no writeback; ext write and writeback to r3 in the same cycle -> r3 holds the writeback value.

Source files
------------

// File: rtl/alu_regfile_pipe.sv
// ---------------------------------------------------------------------------
// alu_regfile_pipe
//
// Two-stage pipelined ALU with an NREGS x DATA_W register file, sitting
// between instruction decode and the branch/PC logic of the en/de-cryption
// datapath. S1 captures the decoded instruction and its operands on accept.
// S2 holds the computed result and drives the outputs. Results flagged for
// writeback are written to the register file on the output handshake, and
// are forwarded to a dependent instruction leaving S1 in that same cycle.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  instruction handshake (accept = in_valid && in_ready)
//   op                   0 ADD, 1 INV, 2 AND, 3 OR, 4 SHR, 5 SHL, 6 BEQ, 7 BNE
//   rs0, rs1, rd         source / destination register addresses
//   wb_en                request writeback of the result to rd
//   src0_sel, src1_sel   operand source: 0 register, 1 zero, 2 imm, 3 zero
//   imm                  immediate operand
//   ext_wr_*             host register load port
//   out_valid/out_ready  result handshake
//   result, ovf          ALU result and signed overflow (ADD only)
//   take_branch          branch decision (BEQ/BNE only)
//   out_rd, out_wb       destination of result and whether it is written back
// ---------------------------------------------------------------------------
module alu_regfile_pipe #(
  parameter  int DATA_W = 8,
  parameter  int NREGS  = 4,
  localparam int ADDR_W = $clog2(NREGS),
  localparam int SH_W   = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] rs0,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rd,
  input  logic              wb_en,
  input  logic [1:0]        src0_sel,
  input  logic [1:0]        src1_sel,
  input  logic [DATA_W-1:0] imm,
  input  logic              ext_wr_en,
  input  logic [ADDR_W-1:0] ext_wr_addr,
  input  logic [DATA_W-1:0] ext_wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              ovf,
  output logic              take_branch,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_wb
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_INV = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_SHR = 3'd4,
    OP_SHL = 3'd5,
    OP_BEQ = 3'd6,
    OP_BNE = 3'd7
  } op_e;

  // Register file
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  // Stage 1: captured instruction and operand values
  logic              s1_valid_q, s1_valid_d;
  op_e               s1_op_q,    s1_op_d;
  logic [ADDR_W-1:0] s1_rs0_q,   s1_rs0_d;
  logic [ADDR_W-1:0] s1_rs1_q,   s1_rs1_d;
  logic              s1_reg0_q,  s1_reg0_d;
  logic              s1_reg1_q,  s1_reg1_d;
  logic [ADDR_W-1:0] s1_rd_q,    s1_rd_d;
  logic              s1_wb_q,    s1_wb_d;
  logic [DATA_W-1:0] s1_a_q,     s1_a_d;
  logic [DATA_W-1:0] s1_b_q,     s1_b_d;

  // Stage 2: computed result driving the outputs
  logic              s2_valid_q,  s2_valid_d;
  logic [DATA_W-1:0] s2_result_q, s2_result_d;
  logic              s2_ovf_q,    s2_ovf_d;
  logic              s2_br_q,     s2_br_d;
  logic [ADDR_W-1:0] s2_rd_q,     s2_rd_d;
  logic              s2_wb_q,     s2_wb_d;

  // Handshake / pipeline control
  logic s2_adv;
  logic s1_adv;
  logic accept;
  logic wb_fire;

  // Operand read at accept and operand selection
  logic [DATA_W-1:0] rd0_val, rd1_val;
  logic [DATA_W-1:0] cap0, cap1;

  // Forwarded operands and ALU outputs
  logic [DATA_W-1:0] opa, opb;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;
  logic              alu_br;
  op_e               in_op;
  logic              in_is_branch;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_adv;
  assign in_ready = !s1_valid_q || s2_adv;
  assign accept   = in_valid && in_ready;
  assign wb_fire  = s2_valid_q && out_ready && s2_wb_q;

  assign in_op        = op_e'(op);
  assign in_is_branch = (in_op == OP_BEQ) || (in_op == OP_BNE);

  // Register read at accept is write-through. The writeback check comes last
  // so that it overrides a same-address host write, matching the register
  // file update priority below.
  always_comb begin
    rd0_val = regs_q[rs0];
    rd1_val = regs_q[rs1];
    if (ext_wr_en && (ext_wr_addr == rs0)) rd0_val = ext_wr_data;
    if (ext_wr_en && (ext_wr_addr == rs1)) rd1_val = ext_wr_data;
    if (wb_fire && (s2_rd_q == rs0)) rd0_val = s2_result_q;
    if (wb_fire && (s2_rd_q == rs1)) rd1_val = s2_result_q;

    cap0 = '0;
    case (src0_sel)
      2'd0:    cap0 = rd0_val;
      2'd2:    cap0 = imm;
      default: cap0 = '0;
    endcase

    cap1 = '0;
    case (src1_sel)
      2'd0:    cap1 = rd1_val;
      2'd2:    cap1 = imm;
      default: cap1 = '0;
    endcase
  end

  // S1 next state: load on accept, otherwise empty out when handing to S2.
  // Branches never write back, whatever wb_en says.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_rs0_d   = s1_rs0_q;
    s1_rs1_d   = s1_rs1_q;
    s1_reg0_d  = s1_reg0_q;
    s1_reg1_d  = s1_reg1_q;
    s1_rd_d    = s1_rd_q;
    s1_wb_d    = s1_wb_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = in_op;
      s1_rs0_d   = rs0;
      s1_rs1_d   = rs1;
      s1_reg0_d  = (src0_sel == 2'd0);
      s1_reg1_d  = (src1_sel == 2'd0);
      s1_rd_d    = rd;
      s1_wb_d    = wb_en && !in_is_branch;
      s1_a_d     = cap0;
      s1_b_d     = cap1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // The S1 instruction may have been captured before the instruction now in
  // S2 was written back, so a pending S2 result replaces a stale register
  // operand. Each operand is checked independently.
  always_comb begin
    opa = s1_a_q;
    opb = s1_b_q;
    if (s1_reg0_q && s2_valid_q && s2_wb_q && (s2_rd_q == s1_rs0_q)) opa = s2_result_q;
    if (s1_reg1_q && s2_valid_q && s2_wb_q && (s2_rd_q == s1_rs1_q)) opb = s2_result_q;
  end

  // ALU. Overflow is the classic same-sign-in, different-sign-out test.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_br  = 1'b0;
    case (s1_op_q)
      OP_ADD: begin
        alu_res = opa + opb;
        alu_ovf = (opa[DATA_W-1] == opb[DATA_W-1]) && (alu_res[DATA_W-1] != opa[DATA_W-1]);
      end
      OP_INV: alu_res = ~opb;
      OP_AND: alu_res = opa & opb;
      OP_OR:  alu_res = opa | opb;
      OP_SHR: alu_res = opa >> opb[SH_W-1:0];
      OP_SHL: alu_res = opa << opb[SH_W-1:0];
      OP_BEQ: alu_br  = (opa == opb);
      OP_BNE: alu_br  = (opa != opb);
      default: begin
        alu_res = '0;
      end
    endcase
  end

  // S2 next state: valid follows S1 whenever S2 may advance; payload only
  // loads when an instruction actually moves, so outputs hold under stall.
  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_ovf_d    = s2_ovf_q;
    s2_br_d     = s2_br_q;
    s2_rd_d     = s2_rd_q;
    s2_wb_d     = s2_wb_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
    end
    if (s1_adv) begin
      s2_result_d = alu_res;
      s2_ovf_d    = alu_ovf;
      s2_br_d     = alu_br;
      s2_rd_d     = s1_rd_q;
      s2_wb_d     = s1_wb_q;
    end
  end

  // Register file update: writeback is applied after the host write so it
  // wins on an address collision; different addresses both land.
  always_comb begin
    regs_d = regs_q;
    if (ext_wr_en) regs_d[ext_wr_addr] = ext_wr_data;
    if (wb_fire)   regs_d[s2_rd_q]     = s2_result_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_ADD;
      s1_rs0_q   <= '0;
      s1_rs1_q   <= '0;
      s1_reg0_q  <= 1'b0;
      s1_reg1_q  <= 1'b0;
      s1_rd_q    <= '0;
      s1_wb_q    <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_rs0_q   <= s1_rs0_d;
      s1_rs1_q   <= s1_rs1_d;
      s1_reg0_q  <= s1_reg0_d;
      s1_reg1_q  <= s1_reg1_d;
      s1_rd_q    <= s1_rd_d;
      s1_wb_q    <= s1_wb_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_ovf_q    <= 1'b0;
      s2_br_q     <= 1'b0;
      s2_rd_q     <= '0;
      s2_wb_q     <= 1'b0;
    end else begin
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_ovf_q    <= s2_ovf_d;
      s2_br_q     <= s2_br_d;
      s2_rd_q     <= s2_rd_d;
      s2_wb_q     <= s2_wb_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign result      = s2_result_q;
  assign ovf         = s2_ovf_q;
  assign take_branch = s2_br_q;
  assign out_rd      = s2_rd_q;
  assign out_wb      = s2_wb_q;

endmodule
